// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the ID/EX held-instruction record.
// Used by id_ex_stage and fwd_mux.
package alu_pkg;

  localparam int ID_EX_WIDTH = 32;
  localparam int ID_EX_AW    = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef struct packed {
    logic [ID_EX_AW-1:0]    rs1_addr;
    logic [ID_EX_AW-1:0]    rs2_addr;
    logic [ID_EX_AW-1:0]    rd_addr;
    logic [ID_EX_WIDTH-1:0] rs1_data;
    logic [ID_EX_WIDTH-1:0] rs2_data;
    logic [ID_EX_WIDTH-1:0] imm;
    logic                   use_imm;
    logic [3:0]             alu_op;
    logic [2:0]             funct3;
    logic [6:0]             opcode;
    logic                   reg_write;
    logic                   mem_read;
  } id_ex_t;

  // True when a writer to rd produces the value a reader of rs needs; x0 never matches.
  function automatic logic rs_match(input logic [ID_EX_AW-1:0] rs,
                                    input logic [ID_EX_AW-1:0] rd,
                                    input logic                we);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// One operand's forwarding select: MEM result over WB data over the registered value.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [WIDTH-1:0]  rs_data,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic [WIDTH-1:0]  mem_result,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_reg_write,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  fwd_data
);

  always_comb begin
    fwd_data = rs_data;
    if (rs_match(rs_addr, mem_rd_addr, mem_reg_write)) begin
      fwd_data = mem_result;
    end else if (rs_match(rs_addr, wb_rd_addr, wb_reg_write)) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with RAW hazard handling.
// Define ID_EX_FORWARD_EN for MEM/WB forwarding; otherwise RAW dependencies stall.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_AW-1:0] dec_rs1_addr,
  input  logic [REG_AW-1:0] dec_rs2_addr,
  input  logic [REG_AW-1:0] dec_rd_addr,
  input  logic [WIDTH-1:0]  dec_rs1_data,
  input  logic [WIDTH-1:0]  dec_rs2_data,
  input  logic [WIDTH-1:0]  dec_imm,
  input  logic              dec_use_imm,
  input  logic [3:0]        dec_alu_op,
  input  logic [2:0]        dec_funct3,
  input  logic [6:0]        dec_opcode,
  input  logic              dec_reg_write,
  input  logic              dec_mem_read,
  input  logic              ex_ready,
  input  logic              flush,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic [WIDTH-1:0]  mem_result,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_reg_write,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  in1,
  output logic [WIDTH-1:0]  rs2_out,
  output logic [3:0]        ALUOp_control,
  output logic [2:0]        funct3,
  output logic [6:0]        opcode,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [WIDTH-1:0]  ex_store_data
);

  id_ex_t ex_q, ex_d;
  logic   ex_valid_q, ex_valid_d;

  logic             load_use;
  logic             hazard;
  logic             accept;
  logic [WIDTH-1:0] rs1_fwd;
  logic [WIDTH-1:0] rs2_fwd;

  // A load in EX cannot supply its data until MEM, so a dependent reader waits one slot.
  assign load_use = ex_valid_q && ex_q.mem_read &&
                    (rs_match(dec_rs1_addr, ex_q.rd_addr, 1'b1) ||
                     rs_match(dec_rs2_addr, ex_q.rd_addr, 1'b1));

`ifdef ID_EX_FORWARD_EN
  assign hazard = load_use;

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr      (ex_q.rs1_addr),
    .rs_data      (ex_q.rs1_data),
    .mem_rd_addr  (mem_rd_addr),
    .mem_reg_write(mem_reg_write),
    .mem_result   (mem_result),
    .wb_rd_addr   (wb_rd_addr),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data),
    .fwd_data     (rs1_fwd)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr      (ex_q.rs2_addr),
    .rs_data      (ex_q.rs2_data),
    .mem_rd_addr  (mem_rd_addr),
    .mem_reg_write(mem_reg_write),
    .mem_result   (mem_result),
    .wb_rd_addr   (wb_rd_addr),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data),
    .fwd_data     (rs2_fwd)
  );
`else
  logic raw_ex;
  logic raw_mem;
  logic unused_fwd;

  // WB needs no check: the register file writes before it is read.
  assign raw_ex  = rs_match(dec_rs1_addr, ex_q.rd_addr, ex_valid_q && ex_q.reg_write) ||
                   rs_match(dec_rs2_addr, ex_q.rd_addr, ex_valid_q && ex_q.reg_write);
  assign raw_mem = rs_match(dec_rs1_addr, mem_rd_addr, mem_reg_write) ||
                   rs_match(dec_rs2_addr, mem_rd_addr, mem_reg_write);
  assign hazard  = load_use || raw_ex || raw_mem;

  assign rs1_fwd = ex_q.rs1_data;
  assign rs2_fwd = ex_q.rs2_data;

  assign unused_fwd = ^{mem_result, wb_rd_addr, wb_reg_write, wb_data,
                        ex_q.rs1_addr, ex_q.rs2_addr};
`endif

  assign dec_ready = rst_n && !flush && !hazard && (!ex_valid_q || ex_ready);
  assign accept    = dec_valid && dec_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns both _d signals; without them
    // the hold case would infer latches.
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (accept) begin
      ex_d.rs1_addr  = dec_rs1_addr;
      ex_d.rs2_addr  = dec_rs2_addr;
      ex_d.rd_addr   = dec_rd_addr;
      ex_d.rs1_data  = dec_rs1_data;
      ex_d.rs2_data  = dec_rs2_data;
      ex_d.imm       = dec_imm;
      ex_d.use_imm   = dec_use_imm;
      ex_d.alu_op    = dec_alu_op;
      ex_d.funct3    = dec_funct3;
      ex_d.opcode    = dec_opcode;
      ex_d.reg_write = dec_reg_write;
      ex_d.mem_read  = dec_mem_read;
      ex_valid_d     = 1'b1;
    end else if (ex_ready || flush) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for every flop; the held fields are ordinary flops,
    // not a memory, so they reset too and every output reads 0 out of reset.
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign in1           = rs1_fwd;
  assign rs2_out       = ex_q.use_imm ? ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ALUOp_control = ex_q.alu_op;
  assign funct3        = ex_q.funct3;
  assign opcode        = ex_q.opcode;
  assign ex_rd_addr    = ex_q.rd_addr;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hazard/flush/reset sequences.
// Expectations follow the build: ID_EX_FORWARD_EN selects forwarding behaviour.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm;
  logic        dec_use_imm;
  logic [3:0]  dec_alu_op;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_opcode;
  logic        dec_reg_write, dec_mem_read;
  logic        ex_ready, flush;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write;
  logic [31:0] mem_result;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] in1, rs2_out;
  logic [3:0]  ALUOp_control;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read;
  logic [31:0] ex_store_data;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rd_addr(dec_rd_addr),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .dec_alu_op(dec_alu_op), .dec_funct3(dec_funct3),
    .dec_opcode(dec_opcode), .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
    .ex_ready(ex_ready), .flush(flush),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .ex_valid(ex_valid), .in1(in1), .rs2_out(rs2_out),
    .ALUOp_control(ALUOp_control), .funct3(funct3), .opcode(opcode),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        ui;
    logic [3:0]  op;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic        rw, mr, rdy, fl;
    logic        e_dready, e_valid;
    logic [31:0] e_in1, e_rs2, e_store;
    logic [3:0]  e_op;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mkv(
      input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm, input logic ui,
      input logic [3:0] op, input logic [2:0] f3, input logic [6:0] opc,
      input logic rw, input logic mr, input logic rdy, input logic fl,
      input logic e_dready, input logic e_valid, input logic [31:0] e_in1,
      input logic [31:0] e_rs2, input logic [31:0] e_store, input logic [3:0] e_op);
    vec_t r;
    r = '{v, rs1, rs2, rd, d1, d2, imm, ui, op, f3, opc, rw, mr, rdy, fl,
          e_dready, e_valid, e_in1, e_rs2, e_store, e_op};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic ui, input logic [3:0] op,
                           input logic [2:0] f3, input logic [6:0] opc,
                           input logic rw, input logic mr);
    dec_valid = v; dec_rs1_addr = rs1; dec_rs2_addr = rs2; dec_rd_addr = rd;
    dec_rs1_data = d1; dec_rs2_data = d2; dec_imm = imm; dec_use_imm = ui;
    dec_alu_op = op; dec_funct3 = f3; dec_opcode = opc;
    dec_reg_write = rw; dec_mem_read = mr;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic we, input logic [31:0] res);
    mem_rd_addr = rd; mem_reg_write = we; mem_result = res;
  endtask

  task automatic set_wb(input logic [4:0] rd, input logic we, input logic [31:0] d);
    wb_rd_addr = rd; wb_reg_write = we; wb_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ADD, ADDI(imm), XOR, SLT held off by 3 cycles of backpressure, then drain.
    tbl[0] = mkv(1,  6,  7,  8, 32'd10,     32'd5,      32'd0, 0, 4'b0010, 3'd0, 7'b0110011, 1, 0, 1, 0,
                 1, 1, 32'd10,     32'd5,          32'd5,      4'b0010);
    tbl[1] = mkv(1,  9,  0, 10, 32'd100,    32'd0, 32'hFFFF_FFFD, 1, 4'b0010, 3'd0, 7'b0010011, 1, 0, 1, 0,
                 1, 1, 32'd100,    32'hFFFF_FFFD,  32'd0,      4'b0010);
    tbl[2] = mkv(1, 11, 12, 13, 32'hF0F0,   32'h0FF0,   32'd0, 0, 4'b0011, 3'd4, 7'b0110011, 1, 0, 1, 0,
                 1, 1, 32'hF0F0,   32'h0FF0,       32'h0FF0,   4'b0011);
    tbl[3] = mkv(1, 14, 15, 16, 32'd1,      32'd2,      32'd0, 0, 4'b0111, 3'd2, 7'b0110011, 1, 0, 0, 0,
                 0, 1, 32'hF0F0,   32'h0FF0,       32'h0FF0,   4'b0011);
    tbl[4] = tbl[3];
    tbl[5] = tbl[3];
    tbl[6] = mkv(1, 14, 15, 16, 32'd1,      32'd2,      32'd0, 0, 4'b0111, 3'd2, 7'b0110011, 1, 0, 1, 0,
                 1, 1, 32'd1,      32'd2,          32'd2,      4'b0111);
    tbl[7] = mkv(0,  0,  0,  0, 32'd0,      32'd0,      32'd0, 0, 4'b0000, 3'd0, 7'b0000000, 0, 0, 1, 0,
                 1, 0, 32'd1,      32'd2,          32'd2,      4'b0111);
    tbl[8] = mkv(0,  0,  0,  0, 32'd0,      32'd0,      32'd0, 0, 4'b0000, 3'd0, 7'b0000000, 0, 0, 0, 0,
                 1, 0, 32'd1,      32'd2,          32'd2,      4'b0111);

    // Reset with an instruction presented.
    rst_n = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    set_mem(0, 0, 0); set_wb(0, 0, 0);
    drive_dec(1, 1, 2, 3, 32'd7, 32'd8, 32'd0, 0, 4'b0010, 3'd0, 7'b0110011, 1, 0);
    #1 check("reset_dec_ready", 32'(dec_ready), 32'd0);
    @(posedge clk); #1;
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_in1", in1, 32'd0);
    check("reset_rs2_out", rs2_out, 32'd0);
    check("reset_aluop", 32'(ALUOp_control), 32'd0);
    check("reset_opcode", 32'(opcode), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_dec(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].d1, tbl[i].d2, tbl[i].imm,
                tbl[i].ui, tbl[i].op, tbl[i].f3, tbl[i].opc, tbl[i].rw, tbl[i].mr);
      ex_ready = tbl[i].rdy; flush = tbl[i].fl;
      #1 check($sformatf("vec%0d_dec_ready", i), 32'(dec_ready), 32'(tbl[i].e_dready));
      @(posedge clk); #1;
      check($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d_in1", i), in1, tbl[i].e_in1);
      check($sformatf("vec%0d_rs2_out", i), rs2_out, tbl[i].e_rs2);
      check($sformatf("vec%0d_store", i), ex_store_data, tbl[i].e_store);
      check($sformatf("vec%0d_aluop", i), 32'(ALUOp_control), 32'(tbl[i].e_op));
    end

    // Load-use: LW x4 then ADD reading x4.
    @(negedge clk); ex_ready = 1'b1;
    drive_dec(1, 2, 0, 4, 32'h100, 32'd0, 32'd8, 1, 4'b0010, 3'd2, 7'b0000011, 1, 1);
    #1 check("lw_dec_ready", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    check("lw_ex_valid", 32'(ex_valid), 32'd1);
    check("lw_mem_read", 32'(ex_mem_read), 32'd1);
    check("lw_rd_addr", 32'(ex_rd_addr), 32'd4);
    check("lw_rs2_out_imm", rs2_out, 32'd8);
    @(negedge clk);
    drive_dec(1, 4, 5, 6, 32'd0, 32'd3, 32'd0, 0, 4'b0010, 3'd0, 7'b0110011, 1, 0);
    #1 check("load_use_dec_ready", 32'(dec_ready), 32'd0);
    @(posedge clk); #1;
    check("load_use_bubble", 32'(ex_valid), 32'd0);
    @(negedge clk); set_mem(4, 1, 32'hABC);
`ifdef ID_EX_FORWARD_EN
    #1 check("load_use_release", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    check("load_use_accept", 32'(ex_valid), 32'd1);
    @(negedge clk); dec_valid = 1'b0; set_mem(0, 0, 0); set_wb(4, 1, 32'hABC);
    #1 check("fwd_wb_load", in1, 32'hABC);
    check("fwd_wb_load_rs2", rs2_out, 32'd3);
`else
    #1 check("raw_mem_dec_ready", 32'(dec_ready), 32'd0);
    @(posedge clk); #1;
    check("raw_mem_bubble", 32'(ex_valid), 32'd0);
    @(negedge clk); set_mem(0, 0, 0); set_wb(4, 1, 32'hABC); dec_rs1_data = 32'hABC;
    #1 check("raw_wb_release", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    check("raw_accept", 32'(ex_valid), 32'd1);
    check("raw_in1", in1, 32'hABC);
    check("raw_rs2_out", rs2_out, 32'd3);
    @(negedge clk); dec_valid = 1'b0; set_wb(0, 0, 0);
`endif
    @(posedge clk); #1;
    check("drain_ex_valid", 32'(ex_valid), 32'd0);

    // MEM over WB priority, then x0 never forwarded.
    @(negedge clk); set_mem(0, 0, 0); set_wb(0, 0, 0); ex_ready = 1'b1;
    drive_dec(1, 3, 0, 7, 32'd1, 32'd0, 32'd0, 0, 4'b0110, 3'd0, 7'b0110011, 1, 0);
    @(posedge clk); #1;
    check("sub_ex_valid", 32'(ex_valid), 32'd1);
    @(negedge clk); dec_valid = 1'b0; ex_ready = 1'b0;
    set_mem(3, 1, 32'd20); set_wb(3, 1, 32'd99);
`ifdef ID_EX_FORWARD_EN
    #1 check("fwd_mem_over_wb", in1, 32'd20);
    @(negedge clk); set_mem(3, 0, 32'd20);
    #1 check("fwd_wb_only", in1, 32'd99);
`else
    #1 check("nofwd_in1_mem", in1, 32'd1);
    @(negedge clk); set_mem(3, 0, 32'd20);
    #1 check("nofwd_in1_wb", in1, 32'd1);
`endif
    check("stall_hold_valid", 32'(ex_valid), 32'd1);
    @(negedge clk); set_mem(0, 1, 32'd7); set_wb(0, 1, 32'd9);
    #1 check("x0_no_fwd_rs2", rs2_out, 32'd0);
    check("x0_no_fwd_store", ex_store_data, 32'd0);
    check("x0_in1_unaffected", in1, 32'd1);

    // Flush with ex_ready=0 and a new instruction presented.
    @(negedge clk); set_mem(0, 0, 0); set_wb(0, 0, 0); ex_ready = 1'b1;
    drive_dec(1, 1, 2, 0, 32'd5, 32'd5, 32'd16, 0, 4'b0110, 3'd0, 7'b1100011, 0, 0);
    #1 check("beq_dec_ready", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    check("beq_opcode", 32'(opcode), 32'h63);
    check("beq_aluop", 32'(ALUOp_control), 32'd6);
    @(negedge clk); flush = 1'b1; ex_ready = 1'b0;
    drive_dec(1, 20, 21, 22, 32'd77, 32'd1, 32'd0, 0, 4'b0010, 3'd0, 7'b0110011, 1, 0);
    #1 check("flush_dec_ready", 32'(dec_ready), 32'd0);
    @(posedge clk); #1;
    check("flush_ex_valid", 32'(ex_valid), 32'd0);
    check("flush_not_accepted", in1, 32'd5);
    @(negedge clk); flush = 1'b0; dec_valid = 1'b0; ex_ready = 1'b1;

    // Reset in the middle of a load-use stall.
    @(negedge clk);
    drive_dec(1, 2, 0, 4, 32'h100, 32'd0, 32'd8, 1, 4'b0010, 3'd2, 7'b0000011, 1, 1);
    @(posedge clk); #1;
    check("lw2_ex_valid", 32'(ex_valid), 32'd1);
    @(negedge clk); ex_ready = 1'b0;
    drive_dec(1, 4, 9, 6, 32'h55, 32'd0, 32'd0, 0, 4'b0010, 3'd0, 7'b0110011, 1, 0);
    #1 check("stall_dec_ready", 32'(dec_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); rst_n = 1'b0;
    #1 check("midstall_reset_dec_ready", 32'(dec_ready), 32'd0);
    @(posedge clk); #1;
    check("rst2_ex_valid", 32'(ex_valid), 32'd0);
    check("rst2_in1", in1, 32'd0);
    check("rst2_rs2_out", rs2_out, 32'd0);
    check("rst2_aluop", 32'(ALUOp_control), 32'd0);
    check("rst2_funct3", 32'(funct3), 32'd0);
    check("rst2_opcode", 32'(opcode), 32'd0);
    check("rst2_rd_addr", 32'(ex_rd_addr), 32'd0);
    check("rst2_reg_write", 32'(ex_reg_write), 32'd0);
    check("rst2_mem_read", 32'(ex_mem_read), 32'd0);
    check("rst2_store", ex_store_data, 32'd0);
    @(negedge clk); rst_n = 1'b1; ex_ready = 1'b1;
    #1 check("post_reset_dec_ready", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    check("post_reset_accept", 32'(ex_valid), 32'd1);
    check("post_reset_in1", in1, 32'h55);

    // ADD x5 then SUB reading x5.
    @(negedge clk);
    drive_dec(1, 1, 2, 5, 32'd1, 32'd2, 32'd0, 0, 4'b0010, 3'd0, 7'b0110011, 1, 0);
    #1 check("add5_dec_ready", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    check("add5_in1", in1, 32'd1);
    @(negedge clk);
    drive_dec(1, 5, 9, 7, 32'd0, 32'd4, 32'd0, 0, 4'b0110, 3'd0, 7'b0110011, 1, 0);
`ifdef ID_EX_FORWARD_EN
    #1 check("b2b_dec_ready", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b_ex_valid", 32'(ex_valid), 32'd1);
    @(negedge clk); dec_valid = 1'b0; set_mem(5, 1, 32'd3);
    #1 check("fwd_mem_b2b", in1, 32'd3);
    check("fwd_mem_b2b_rs2", rs2_out, 32'd4);
`else
    #1 check("raw_ex_dec_ready", 32'(dec_ready), 32'd0);
    @(posedge clk); #1;
    check("raw_ex_bubble", 32'(ex_valid), 32'd0);
    @(negedge clk); set_mem(5, 1, 32'd3);
    #1 check("raw_mem2_dec_ready", 32'(dec_ready), 32'd0);
    @(posedge clk); #1;
    check("raw_mem2_bubble", 32'(ex_valid), 32'd0);
    @(negedge clk); set_mem(0, 0, 0); set_wb(5, 1, 32'd3); dec_rs1_data = 32'd3;
    #1 check("raw_wb2_dec_ready", 32'(dec_ready), 32'd1);
    @(posedge clk); #1;
    check("sub_accept", 32'(ex_valid), 32'd1);
    check("sub_in1", in1, 32'd3);
    check("sub_rs2_out", rs2_out, 32'd4);
    check("sub_aluop", 32'(ALUOp_control), 32'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU. It registers one decoded instruction and drives the ALU operand and control inputs: `in1`, `rs2_out`, `ALUOp_control`, `funct3` and `opcode`. It resolves RAW hazards in two ways: combinational forwarding from the MEM and WB stages, and load-use stall/bubble insertion. It moves instructions with a valid/ready handshake and accepts a branch-taken flush.

## Interface
- `WIDTH`, 32, datapath width
- `REG_AW`, 5, register address width
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `dec_valid` in 1: decode presents an instruction
- `dec_ready` out 1: stage accepts this cycle
- `dec_rs1_addr`, `dec_rs2_addr`, `dec_rd_addr` in REG_AW: source/destination registers
- `dec_rs1_data`, `dec_rs2_data` in WIDTH: register-file read data
- `dec_imm` in WIDTH: sign-extended immediate
- `dec_use_imm` in 1: `rs2_out` takes the immediate
- `dec_alu_op` in 4, `dec_funct3` in 3, `dec_opcode` in 7: ALU control
- `dec_reg_write`, `dec_mem_read` in 1: writeback / load flags
- `ex_ready` in 1: EX/MEM consumes the held instruction
- `flush` in 1: branch taken; kill held and presented instruction
- `mem_rd_addr` in REG_AW, `mem_reg_write` in 1, `mem_result` in WIDTH: MEM-stage forward source
- `wb_rd_addr` in REG_AW, `wb_reg_write` in 1, `wb_data` in WIDTH: WB-stage forward source
- `ex_valid` out 1: held instruction valid
- `in1`, `rs2_out` out WIDTH: ALU operands
- `ALUOp_control` out 4, `funct3` out 3, `opcode` out 7: ALU control
- `ex_rd_addr` out REG_AW, `ex_reg_write`, `ex_mem_read` out 1: passed downstream
- `ex_store_data` out WIDTH: forwarded rs2 for stores

## Operation
- **Accept rule.** An instruction is accepted when `dec_valid && dec_ready`.
  - `dec_ready = !flush && !hazard && (!ex_valid || ex_ready)`.
- **Hold register next state.**
  - Accept: load all `dec_*` fields and set `ex_valid=1`.
  - Else, if `ex_ready` or `flush`: set `ex_valid=0`; fields hold their values.
  - Else: hold everything.
- **Load-use hazard.** Asserted when `ex_valid && ex_mem_read && ex_rd_addr!=0` and `ex_rd_addr` equals `dec_rs1_addr` or `dec_rs2_addr`. While asserted, a bubble is inserted.
- **Forwarding.** Applies independently to the registered rs1 and rs2 values.
  - If `mem_reg_write && mem_rd_addr!=0 && mem_rd_addr==rs_q`, use `mem_result`.
  - Else if the same test passes for WB, use `wb_data`.
  - Else use the registered data. MEM has priority over WB.
  - x0 is never forwarded.
- **Operand outputs.**
  - `in1` = forwarded rs1.
  - `rs2_out` = `use_imm_q ? imm_q : forwarded rs2`.
  - `ex_store_data` = forwarded rs2 always.
- **Passthrough.** `ALUOp_control`, `funct3` and `opcode` are passed through registered, unmodified. Branches (opcode 1100011, ALUOp 0110) need no special handling.
- **Priority.** Reset > flush > stall.
  - Flush with `ex_ready=0` still clears `ex_valid`.
- **Reset outputs.** All outputs are 0 after reset, including `ex_valid`.
  - `dec_ready` is 0 during the reset cycle.
  - Reset mid-stall drops the held instruction.

## Timing
- One-cycle latency from accept edge to `ex_valid`/outputs.
- Forwarding and `rs2_out` select are combinational from MEM/WB inputs; no added cycle.
- `dec_ready` is combinational from `flush`, `ex_ready` and the hazard logic; it has no dependency on `dec_valid`.
- A load-use stall lasts exactly one cycle when `ex_ready=1`.
- Back-to-back accepts give full throughput (1 instr/cycle).

## Configuration
- `ID_EX_FORWARD_EN` defined:
  - Forwarding as above.
  - Stalls only on load-use.
- `ID_EX_FORWARD_EN` undefined:
  - Operands come straight from registered data.
  - `hazard` also asserts when `dec_rs1_addr`/`dec_rs2_addr` (nonzero) match a writing instruction in EX (`ex_valid && ex_reg_write`) or MEM (`mem_reg_write`).
  - The register file is write-before-read, so the WB stage needs no check.

## Structure
- Package `alu_pkg` holds:
  - ALUOp constants: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000, SLL 1001, SRL 1010, SRA 1011.
  - Opcode constants: BRANCH 1100011, LOAD 0000011, STORE 0100011, OP 0110011, OP_IMM 0010011.
  - A packed struct `id_ex_t` for the held fields.
- Sub-module `fwd_mux` (one operand's MEM/WB priority select), instantiated twice.

## Test plan
- **Plain accept:** ADD, rs1=10, rs2=5, `ex_ready=1` → next cycle `ex_valid=1`, `in1=10`, `rs2_out=5`, `ALUOp_control=0010`.
- **MEM/WB forward priority:** both MEM and WB write x3 (MEM 20, WB 99), held SUB reads rs1=x3 → `in1=20`; MEM write to x0 with value 7 → not forwarded.
- **Load-use:** held LW x4 followed by ADD reading x4 → `dec_ready=0` for one cycle, `ex_valid=0` bubble, then ADD accepted.
- **Backpressure:** `ex_ready=0` for 3 cycles → outputs stable, `dec_ready=0`; release → next instruction accepted on the same edge.
- **Flush and reset:** BEQ held with `flush=1`, `dec_valid=1` → `ex_valid=0` next cycle and the presented instruction is not accepted; `rst_n=0` mid-stall → all outputs 0.
- **Forwarding disabled:** without `ID_EX_FORWARD_EN`, ADD x5 followed by SUB reading x5 → SUB stalls until ADD has left MEM.
